// File: rtl/multdiv_pkg.sv
// Shared state encoding, opcodes and latencies for the multiply/divide unit.
// Latency constants count cycles from the start edge to the data_resultRDY cycle.
package multdiv_pkg;
  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

  localparam logic [4:0] ALU_OP_MULT = 5'd6;
  localparam logic [4:0] ALU_OP_DIV  = 5'd7;
  localparam int         MULT_LAT    = 17;
  localparam int         DIV_LAT     = 34;
  localparam int         CNT_W       = 5;
endpackage

// File: rtl/multdiv_if.sv
// Start/operand/result bundle between execute control and the multiply/divide unit.
// No handshake: starts are single-cycle pulses, results are a one-cycle valid pulse.
interface multdiv_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_booth_enc.sv
// Radix-4 Booth digit decoder: {b[2i+1], b[2i], b[2i-1]} -> digit in {0, +-1, +-2}.
// Purely combinational, no latency, no flow control.
module multdiv_booth_enc (
  input  logic [2:0] bits,
  output logic       neg,
  output logic       zero,
  output logic       two
);
  always_comb begin
    neg  = bits[2] & ~(bits[1] & bits[0]);
    zero = (bits == 3'b000) || (bits == 3'b111);
    two  = (bits == 3'b011) || (bits == 3'b100);
  end
endmodule

// File: rtl/multdiv_unit.sv
// Signed multiply (RDY at cycle 17) / divide (RDY at cycle 34); MULTDIV_EARLY_DIV0_EN makes div-by-zero finish in cycle 1.
// No backpressure: busy stalls the pipe, data_resultRDY pulses once and the result is held until the next completion.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MULT_ITERS = WIDTH / 2,
  parameter int DIV_ITERS  = WIDTH
) (
  input logic      clock,
  input logic      reset,
  multdiv_if.slave bus
);
  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               start, mult_last, div_last;

  logic [2*WIDTH:0]   prod, prod_step;
  logic [WIDTH-1:0]   mcand;
  logic               b_neg, b_zero, b_two;
  logic signed [WIDTH+1:0] m_ext, pp, sum;
  logic               mult_ovf;

  logic [WIDTH-1:0]   rem, quo, dvs, rem_step, quo_step;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               div_neg, div_zero, div_ovf;

  logic [WIDTH-1:0]   result_q;
  logic               exc_q;

  assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
  assign mult_last = (cnt == CNT_W'(MULT_ITERS - 1));
  assign div_last  = (cnt == CNT_W'(DIV_ITERS - 1));
  assign abs_a     = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign abs_b     = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;

  multdiv_booth_enc u_booth_enc (
    .bits (prod[2:0]),
    .neg  (b_neg),
    .zero (b_zero),
    .two  (b_two)
  );

  // prod = {hi, lo, extra}: hi accumulates, lo holds the unconsumed multiplier bits.
  always_comb begin
    m_ext = {{2{mcand[WIDTH-1]}}, mcand};
    pp    = '0;
    if (!b_zero) pp = b_two ? (m_ext <<< 1) : m_ext;
    if (b_neg) pp = -pp;
    sum       = $signed({{2{prod[2*WIDTH]}}, prod[2*WIDTH:WIDTH+1]}) + pp;
    prod_step = {sum, prod[WIDTH:2]};
    mult_ovf  = !((&prod_step[2*WIDTH:WIDTH]) || (~|prod_step[2*WIDTH:WIDTH]));
  end

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    ge       = shifted >= {1'b0, dvs};
    rem_step = ge ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
    quo_step = {quo[WIDTH-2:0], ge};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    bus.busy           = (state == MULT) || (state == DIV) || (state == FIX);
    bus.data_resultRDY = (state == DONE);
    if (bus.ctrl_MULT) begin
      state_nxt = MULT;
    end else if (bus.ctrl_DIV) begin
`ifdef MULTDIV_EARLY_DIV0_EN
      state_nxt = (bus.data_operandB == '0) ? DONE : DIV;
`else
      state_nxt = DIV;
`endif
    end else begin
      case (state)
        MULT:    if (mult_last) state_nxt = DONE;
        DIV:     if (div_last) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      prod     <= '0;
      mcand    <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      div_neg  <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      if (bus.ctrl_MULT) begin
        mcand <= bus.data_operandA;
        prod  <= {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
      end else begin
        rem      <= '0;
        quo      <= abs_a;
        dvs      <= abs_b;
        div_neg  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        div_zero <= (bus.data_operandB == '0);
        div_ovf  <= (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.data_operandB);
`ifdef MULTDIV_EARLY_DIV0_EN
        if (bus.data_operandB == '0) begin
          result_q <= '0;
          exc_q    <= 1'b1;
        end
`endif
      end
    end else begin
      case (state)
        MULT: begin
          prod <= prod_step;
          cnt  <= mult_last ? '0 : cnt + 1'b1;
          if (mult_last) begin
            result_q <= prod_step[WIDTH:1];
            exc_q    <= mult_ovf;
          end
        end
        DIV: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= div_last ? '0 : cnt + 1'b1;
        end
        FIX: begin
          // Magnitude quotient is exact except for sign; div-by-zero forces 0.
          result_q <= div_zero ? '0 : (div_neg ? -quo : quo);
          exc_q    <= div_zero | div_ovf;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed checks of multdiv_unit: latency, busy window, results, exceptions, restart and async reset.
module tb_multdiv_unit;
  import multdiv_pkg::*;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  multdiv_if #(.WIDTH(32)) bus ();

  multdiv_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = 32'hDEAD_BEEF;
    bus.data_operandB = 32'h1234_5678;
  endtask

  // Counts RDY/busy over a bounded window after the start edge (cycle 0).
  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input int window, output int rdy_cyc, output int rdy_cnt,
                        output int busy_first, output int busy_last,
                        output logic [31:0] res, output logic exc);
    rdy_cyc = 0; rdy_cnt = 0; busy_first = 0; busy_last = 0; res = 'x; exc = 1'bx;
    kick(m, d, a, b);
    for (int c = 1; c <= window; c++) begin
      @(negedge clock);
      if (bus.busy) begin
        if (busy_first == 0) busy_first = c;
        busy_last = c;
      end
      if (bus.data_resultRDY) begin
        rdy_cnt++;
        if (rdy_cyc == 0) begin
          rdy_cyc = c;
          res     = bus.data_result;
          exc     = bus.data_exception;
        end
      end
    end
  endtask

  initial begin
    int          rc, rn, bf, bl, stray;
    logic [31:0] res;
    logic        exc;

    reset = 1'b1;
    bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0; bus.data_operandB = '0;
    repeat (2) @(negedge clock);
    check("reset_result", bus.data_result, 32'h0);
    check("reset_exc", {31'b0, bus.data_exception}, 32'h0);
    check("reset_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // 7 * -3
    run_op(1, 0, 32'd7, -32'sd3, 25, rc, rn, bf, bl, res, exc);
    check("m1_rdy_cyc", rc, MULT_LAT);
    check("m1_rdy_cnt", rn, 1);
    check("m1_busy_first", bf, 1);
    check("m1_busy_last", bl, 16);
    check("m1_result", res, 32'hFFFF_FFEB);
    check("m1_exc", {31'b0, exc}, 32'h0);
    check("m1_held", bus.data_result, 32'hFFFF_FFEB);

    run_op(1, 0, 32'h0001_0000, 32'h0001_0000, 25, rc, rn, bf, bl, res, exc);
    check("m2_result", res, 32'h0);
    check("m2_exc", {31'b0, exc}, 32'h1);

    run_op(1, 0, 32'h8000_0000, 32'h1, 25, rc, rn, bf, bl, res, exc);
    check("m3_result", res, 32'h8000_0000);
    check("m3_exc", {31'b0, exc}, 32'h0);

    // -7 / 2
    run_op(0, 1, -32'sd7, 32'd2, 40, rc, rn, bf, bl, res, exc);
    check("d1_rdy_cyc", rc, DIV_LAT);
    check("d1_rdy_cnt", rn, 1);
    check("d1_busy_last", bl, 33);
    check("d1_result", res, 32'hFFFF_FFFD);
    check("d1_exc", {31'b0, exc}, 32'h0);

    run_op(0, 1, 32'd100, 32'd7, 40, rc, rn, bf, bl, res, exc);
    check("d2_result", res, 32'd14);

    run_op(0, 1, 32'd5, 32'd0, 40, rc, rn, bf, bl, res, exc);
`ifdef MULTDIV_EARLY_DIV0_EN
    check("dz_rdy_cyc", rc, 1);
    check("dz_busy_first", bf, 0);
`else
    check("dz_rdy_cyc", rc, DIV_LAT);
    check("dz_busy_first", bf, 1);
`endif
    check("dz_rdy_cnt", rn, 1);
    check("dz_result", res, 32'h0);
    check("dz_exc", {31'b0, exc}, 32'h1);

    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 40, rc, rn, bf, bl, res, exc);
    check("dov_result", res, 32'h8000_0000);
    check("dov_exc", {31'b0, exc}, 32'h1);

    // Multiply aborted by a divide restart
    stray = 0;
    kick(1, 0, 32'd9, 32'd9);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      if (bus.data_resultRDY) stray++;
    end
    run_op(0, 1, 32'd20, 32'd4, 40, rc, rn, bf, bl, res, exc);
    check("rs_stray_rdy", stray, 0);
    check("rs_rdy_cyc", rc, DIV_LAT);
    check("rs_rdy_cnt", rn, 1);
    check("rs_result", res, 32'd5);

    run_op(1, 1, 32'd6, 32'd7, 40, rc, rn, bf, bl, res, exc);
    check("both_rdy_cyc", rc, MULT_LAT);
    check("both_result", res, 32'd42);

    // Asynchronous reset in the middle of a divide
    kick(0, 1, 32'd100, 32'd7);
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("ar_result", bus.data_result, 32'h0);
    check("ar_exc", {31'b0, bus.data_exception}, 32'h0);
    check("ar_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
    check("ar_busy", {31'b0, bus.busy}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    stray = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (bus.data_resultRDY || bus.busy) stray++;
    end
    check("ar_no_rdy", stray, 0);

    run_op(1, 0, 32'd3, 32'd4, 25, rc, rn, bf, bl, res, exc);
    check("ar_m_rdy_cyc", rc, MULT_LAT);
    check("ar_m_result", res, 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
